// File: rtl/router_pkg.sv
// Shared definitions for the router output buffer.
//   WIDTH / DEPTH / ADDR_W : default byte width, entry count, pointer index width
//   HDR_LEN_MSB/LSB        : bit range of the payload length field in a header byte
//   PKT_CNT_W              : width of the remaining-byte counter
//   entry_t                : stored word, header tag above the data byte
package router_pkg;
  localparam int WIDTH       = 8;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int PKT_CNT_W   = 6;

  typedef struct packed {
    logic             tag;
    logic [WIDTH-1:0] data;
  } entry_t;
endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write strobe
//   waddr : write index
//   wdata : word written at the rising edge when we is high
//   raddr : read index
//   rdata : word at raddr (combinational)
// Contents are not reset; the pointers in the parent define what is valid.
module router_fifo_mem #(
  parameter int WORD_W = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   soft_reset : synchronous flush on destination timeout
//   write_enb  : write data_in this cycle
//   lfd_state  : data_in is a header byte (stored as tag)
//   data_in    : byte from the register stage
//   read_enb   : read request from the destination
//   data_out   : registered read byte
//   data_valid : data_out holds a byte read in the previous cycle
//   pkt_done   : pulses alongside the last (parity) byte of a packet
//   full/empty : occupancy flags from the registered pointers
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH  = router_pkg::WIDTH,
  parameter int DEPTH  = router_pkg::DEPTH,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             pkt_done,
  output logic             full,
  output logic             empty
);

  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic               wr_fire;
  logic               rd_fire;
  logic               flush;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [PKT_CNT_W-1:0] hdr_len;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign flush   = rst || soft_reset;
  assign wr_fire = write_enb && !full && !flush;
  assign rd_fire = read_enb && !empty && !flush;

  assign wr_entry = '{tag: lfd_state, data: data_in};
  assign hdr_len  = rd_entry.data[HDR_LEN_MSB:HDR_LEN_LSB];

  router_fifo_mem #(
    .WORD_W (WIDTH + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_entry)
  );

  // Read stage: the entry at rd_ptr is registered onto data_out one cycle after the request.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      data_valid <= rd_fire;
      pkt_done   <= 1'b0;
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry.data;
        if (rd_entry.tag) begin
          // Header reload also abandons any truncated packet still counting.
          pkt_cnt <= hdr_len + 1'b1;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - 1'b1;
          if (pkt_cnt == PKT_CNT_W'(1)) pkt_done <= 1'b1;
        end
        // Untagged byte with a zero count is an orphan: passed through, no count change.
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_done;
  logic       full;
  logic       empty;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pkt_done   (pkt_done),
    .full       (full),
    .empty      (empty)
  );

  // One clock: drive inputs, take the edge, settle #1 after it.
  task automatic cyc(input logic we, input logic lfd, input logic [7:0] d,
                     input logic re, input logic sr, input logic r);
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = d;
    read_enb   = re;
    soft_reset = sr;
    rst        = r;
    @(posedge clk);
    #1;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    cyc(1'b1, lfd, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pkt1 [5];
    logic [7:0] pkt3 [3];
    pkt1 = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    pkt3 = '{8'h04, 8'h5A, 8'h04};

    // Reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_valid", data_valid, 1'b0);
    chk1("rst_done", pkt_done, 1'b0);
    chk8("rst_dout", data_out, 8'h00);

    // 1: one packet of length 3
    for (int i = 0; i < 5; i++) wr(i == 0, pkt1[i]);
    chk1("t1_not_empty", empty, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk8("t1_data", data_out, pkt1[i]);
      chk1("t1_valid", data_valid, 1'b1);
      chk1("t1_done", pkt_done, i == 4);
    end
    idle();
    chk1("t1_valid_idle", data_valid, 1'b0);
    chk1("t1_done_idle", pkt_done, 1'b0);
    chk1("t1_empty", empty, 1'b1);

    // 2: fill, overflow drop, drain
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 8'(8'h10 + i));
      chk1("t2_full_fill", full, i == 15);
    end
    wr(1'b0, 8'hFF);
    chk1("t2_full_after_drop", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk8("t2_data", data_out, 8'(8'h10 + i));
      chk1("t2_done", pkt_done, 1'b0);
    end
    chk1("t2_empty", empty, 1'b1);
    rd();
    chk1("t2_rd_empty_valid", data_valid, 1'b0);
    chk8("t2_rd_empty_hold", data_out, 8'h1F);

    // 3: simultaneous read/write on full, then on empty
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h40 + i));
    chk1("t3_full", full, 1'b1);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk8("t3_full_rd_data", data_out, 8'h40);
    chk1("t3_full_rd_valid", data_valid, 1'b1);
    chk1("t3_count15", full, 1'b0);
    wr(1'b0, 8'h99);
    chk1("t3_full_again", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk8("t3_data", data_out, (i == 15) ? 8'h99 : 8'(8'h41 + i));
    end
    chk1("t3_empty", empty, 1'b1);
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    chk1("t3_empty_both_valid", data_valid, 1'b0);
    chk1("t3_empty_both_stored", empty, 1'b0);
    chk8("t3_empty_both_hold", data_out, 8'h99);
    rd();
    chk8("t3_stored_data", data_out, 8'h77);
    chk1("t3_stored_valid", data_valid, 1'b1);

    // 4: zero-length packet
    wr(1'b1, 8'h00);
    wr(1'b0, 8'hAA);
    rd();
    chk8("t4_hdr", data_out, 8'h00);
    chk1("t4_hdr_done", pkt_done, 1'b0);
    rd();
    chk8("t4_par", data_out, 8'hAA);
    chk1("t4_par_done", pkt_done, 1'b1);
    idle();
    chk1("t4_done_clear", pkt_done, 1'b0);

    // 5: soft reset mid-packet, then a fresh packet
    for (int i = 0; i < 5; i++) wr(i == 0, pkt1[i]);
    rd();
    rd();
    chk8("t5_second", data_out, 8'h11);
    chk8("t5_cnt_mid", 8'(dut.pkt_cnt), 8'd3);
    cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
    chk1("t5_empty", empty, 1'b1);
    chk1("t5_valid", data_valid, 1'b0);
    chk1("t5_done", pkt_done, 1'b0);
    chk8("t5_cnt", 8'(dut.pkt_cnt), 8'd0);
    chk8("t5_dout", data_out, 8'h00);
    for (int i = 0; i < 3; i++) wr(i == 0, pkt3[i]);
    for (int i = 0; i < 3; i++) begin
      rd();
      chk8("t5_new_data", data_out, pkt3[i]);
      chk1("t5_new_done", pkt_done, i == 2);
    end
    chk1("t5_new_empty", empty, 1'b1);

    // 6: pointer wrap with occupancy 1, reset mid-run
    wr(1'b0, 8'h80);
    for (int i = 1; i < 36; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
      chk8("t6_data", data_out, 8'(8'h80 + i - 1));
      chk1("t6_empty", empty, 1'b0);
      chk1("t6_full", full, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk1("t6_rst_empty", empty, 1'b1);
    chk1("t6_rst_full", full, 1'b0);
    chk1("t6_rst_valid", data_valid, 1'b0);
    chk8("t6_rst_dout", data_out, 8'h00);
    wr(1'b0, 8'hC0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
      chk8("t6_post_data", data_out, 8'(8'hC0 + i - 1));
    end
    rd();
    chk8("t6_post_last", data_out, 8'hC3);
    chk1("t6_post_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
